orv64_bp_ctrl: RTL

Debug breakpoint controller for the orv64 core. It owns the configuration registers that drive the PC/instret breakpoint comparator, and turns the comparator's `bp_stall` pulse into a halt request to the pipeline. It sequences halt, drain, resume and single-step, and suppresses re-triggering on the instruction being resumed. It sits between the debug register bus and the core/comparator.

---
 rtl/orv64_bp_ctrl_if.sv | 23 ++
 rtl/orv64_bp_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/orv64_bp_ctrl_if.sv
// Debug register bus between the debug module and the breakpoint controller.
// The master issues strobes; every strobe is accepted, and a read returns
// its data one cycle later with cfg_rvalid.
interface orv64_bp_ctrl_if #(
  parameter int DATA_W = 64
) ();
  logic              cfg_valid;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_rvalid;
  logic [DATA_W-1:0] cfg_rdata;

  modport master (
    output cfg_valid, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rvalid, cfg_rdata
  );

  modport slave (
    input  cfg_valid, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rvalid, cfg_rdata
  );
endinterface

// File: rtl/orv64_bp_ctrl.sv
// orv64 debug breakpoint controller: config registers for the PC/instret
// comparator plus the halt / drain / resume / single-step sequencer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | core running; breakpoint hit or debug halt request stops it
// HALT_WAIT | halt requested, waiting for the pipeline to drain
// HALTED    | core halted and drained; waits for step or resume
// STEP      | core released for exactly one retiring instruction
module orv64_bp_ctrl #(
  parameter int VADDR_W = 39,
  parameter int DATA_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  orv64_bp_ctrl_if.slave     cfg,
  output logic [VADDR_W-1:0] bp_if_pc_0,
  output logic [VADDR_W-1:0] bp_if_pc_1,
  output logic [VADDR_W-1:0] bp_if_pc_2,
  output logic [VADDR_W-1:0] bp_if_pc_3,
  output logic [VADDR_W-1:0] bp_wb_pc_0,
  output logic [VADDR_W-1:0] bp_wb_pc_1,
  output logic [VADDR_W-1:0] bp_wb_pc_2,
  output logic [VADDR_W-1:0] bp_wb_pc_3,
  output logic               en_bp_if_pc_0,
  output logic               en_bp_if_pc_1,
  output logic               en_bp_if_pc_2,
  output logic               en_bp_if_pc_3,
  output logic               en_bp_wb_pc_0,
  output logic               en_bp_wb_pc_1,
  output logic               en_bp_wb_pc_2,
  output logic               en_bp_wb_pc_3,
  output logic [DATA_W-1:0]  instret_bp,
  output logic               instret_bp_en,
  input  logic               bp_stall,
  input  logic               wb_valid,
  input  logic               core_idle,
  input  logic               dbg_halt_req,
  input  logic               resume_req,
  input  logic               step_req,
  output logic               core_halt_req,
  output logic               halted,
  output logic [1:0]         halt_cause
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2,
    STEP      = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_BP    = 2'd1;
  localparam logic [1:0] CAUSE_STEP  = 2'd2;
  localparam logic [1:0] CAUSE_DEBUG = 2'd3;

  logic [VADDR_W-1:0] if_pc [4];
  logic [VADDR_W-1:0] wb_pc [4];
  logic [DATA_W-1:0]  instret_val;
  logic [8:0]         en_mask;

  state_t             state;
  logic               skip;
  logic [1:0]         cause;
  logic [15:0]        hit_cnt;

  logic [31:0]        status;
  logic [DATA_W-1:0]  rd_mux;
  logic               cfg_wr;
  logic               cfg_rd;

  assign cfg_wr = cfg.cfg_valid & cfg.cfg_we;
  assign cfg_rd = cfg.cfg_valid & ~cfg.cfg_we;

  // Register file writes; comparator outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if_pc[i] <= '0;
        wb_pc[i] <= '0;
      end
      instret_val <= '0;
      en_mask     <= '0;
    end else if (cfg_wr) begin
      case (cfg.cfg_addr)
        4'd0, 4'd1, 4'd2, 4'd3: if_pc[cfg.cfg_addr[1:0]] <= cfg.cfg_wdata[VADDR_W-1:0];
        4'd4, 4'd5, 4'd6, 4'd7: wb_pc[cfg.cfg_addr[1:0]] <= cfg.cfg_wdata[VADDR_W-1:0];
        4'd8:                   instret_val <= cfg.cfg_wdata;
        4'd9:                   en_mask <= cfg.cfg_wdata[8:0];
        default: ;
      endcase
    end
  end

  assign bp_if_pc_0    = if_pc[0];
  assign bp_if_pc_1    = if_pc[1];
  assign bp_if_pc_2    = if_pc[2];
  assign bp_if_pc_3    = if_pc[3];
  assign bp_wb_pc_0    = wb_pc[0];
  assign bp_wb_pc_1    = wb_pc[1];
  assign bp_wb_pc_2    = wb_pc[2];
  assign bp_wb_pc_3    = wb_pc[3];
  assign en_bp_if_pc_0 = en_mask[0];
  assign en_bp_if_pc_1 = en_mask[1];
  assign en_bp_if_pc_2 = en_mask[2];
  assign en_bp_if_pc_3 = en_mask[3];
  assign en_bp_wb_pc_0 = en_mask[4];
  assign en_bp_wb_pc_1 = en_mask[5];
  assign en_bp_wb_pc_2 = en_mask[6];
  assign en_bp_wb_pc_3 = en_mask[7];
  assign instret_bp    = instret_val;
  assign instret_bp_en = en_mask[8];

  assign status = {hit_cnt, 11'd0, state, halted, cause};

  // Read-data select; unmapped addresses and unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (cfg.cfg_addr)
      4'd0, 4'd1, 4'd2, 4'd3: rd_mux[VADDR_W-1:0] = if_pc[cfg.cfg_addr[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7: rd_mux[VADDR_W-1:0] = wb_pc[cfg.cfg_addr[1:0]];
      4'd8:                   rd_mux = instret_val;
      4'd9:                   rd_mux[8:0] = en_mask;
      4'd10:                  rd_mux[31:0] = status;
      default: ;
    endcase
  end

  // Registered read return; rdata holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg.cfg_rvalid <= 1'b0;
      cfg.cfg_rdata  <= '0;
    end else begin
      cfg.cfg_rvalid <= cfg_rd;
      if (cfg_rd) cfg.cfg_rdata <= rd_mux;
    end
  end

  // Halt sequencer; outputs are updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      skip          <= 1'b0;
      cause         <= CAUSE_NONE;
      hit_cnt       <= '0;
      core_halt_req <= 1'b0;
      halted        <= 1'b0;
    end else begin
      // The first retirement after leaving HALTED moves past the breakpointed
      // instruction, so the comparator is trusted again from then on.
      if (wb_valid) skip <= 1'b0;
      case (state)
        RUN: begin
          if (bp_stall && !skip) begin
            state         <= HALT_WAIT;
            cause         <= CAUSE_BP;
            core_halt_req <= 1'b1;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else if (dbg_halt_req) begin
            state         <= HALT_WAIT;
            cause         <= CAUSE_DEBUG;
            core_halt_req <= 1'b1;
          end
        end
        HALT_WAIT: begin
          if (core_idle) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (step_req || resume_req) begin
            state         <= step_req ? STEP : RUN;
            skip          <= 1'b1;
            cause         <= CAUSE_NONE;
            halted        <= 1'b0;
            core_halt_req <= 1'b0;
          end
        end
        STEP: begin
          // skip stays set until the retirement that ends the step, so
          // bp_stall never matters here.
          if (wb_valid) begin
            state         <= HALT_WAIT;
            cause         <= CAUSE_STEP;
            core_halt_req <= 1'b1;
          end else if (dbg_halt_req) begin
            state         <= HALT_WAIT;
            cause         <= CAUSE_DEBUG;
            core_halt_req <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign halt_cause = cause;

endmodule
